// File: rtl/mem_port_arbiter.sv
// Arbiter for the shared fetch/load-store memory port of the MIPS soft core.
// Data wins by default; a starvation counter forces a fetch grant after STARVE_MAX data grants.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          sel,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  localparam logic [3:0] LAT_LOAD   = 4'(MEM_LAT - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_e        state_q, state_d;
  logic          sel_q, sel_d;
  logic          is_store_q, is_store_d;
  logic [3:0]    lat_cnt_q, lat_cnt_d;
  logic [3:0]    starve_q, starve_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic          if_ack_q, if_ack_d;
  logic          d_ack_q, d_ack_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d    = state_q;
    sel_d      = sel_q;
    is_store_d = is_store_q;
    lat_cnt_d  = lat_cnt_q;
    starve_d   = starve_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    mem_en_d   = 1'b0;
    mem_we_d   = 1'b0;
    if_ack_d   = 1'b0;
    d_ack_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          state_d  = ISSUE;
          mem_en_d = 1'b1;
          if (d_req && (!if_req || starve_q < STARVE_LIM)) begin
            sel_d      = 1'b1;
            is_store_d = d_we;
            mem_we_d   = d_we;
            if (if_req) starve_d = starve_q + 4'd1;
          end else begin
            sel_d      = 1'b0;
            is_store_d = 1'b0;
            starve_d   = 4'd0;
          end
        end
      end
      ISSUE: begin
        lat_cnt_d = LAT_LOAD;
        state_d   = WAIT;
      end
      WAIT: begin
        if (lat_cnt_q == 4'd0) begin
          // Only the owner's read register is written; stores leave d_rdata alone.
          if (!sel_q)           if_rdata_d = mem_rdata;
          else if (!is_store_q) d_rdata_d  = mem_rdata;
          if_ack_d = !sel_q;
          d_ack_d  = sel_q;
          state_d  = DONE;
        end else begin
          lat_cnt_d = lat_cnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sel_q      <= 1'b0;
      is_store_q <= 1'b0;
      lat_cnt_q  <= 4'd0;
      starve_q   <= 4'd0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q    <= state_d;
      sel_q      <= sel_d;
      is_store_q <= is_store_d;
      lat_cnt_q  <= lat_cnt_d;
      starve_q   <= starve_d;
      mem_en_q   <= mem_en_d;
      mem_we_q   <= mem_we_d;
      if_ack_q   <= if_ack_d;
      d_ack_q    <= d_ack_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign if_ack    = if_ack_q;
  assign d_ack     = d_ack_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign sel       = sel_q;
  assign busy      = (state_q != IDLE);
  assign mem_addr  = sel_q ? d_addr : if_addr;
  assign mem_wdata = d_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed and randomized transactions against a
// transaction-level model (grant rule, fixed MEM_LAT+2 ack latency, capture-edge data).
module tb_mem_port_arbiter;

  localparam int LAT        = 2;
  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic        if_ack, d_ack, mem_en, mem_we, sel, busy;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;

  // Latency-sweep instances: index 0 has MEM_LAT=1, index 1 has MEM_LAT=5.
  logic [1:0]       s_if_req, s_if_ack, s_d_ack, s_mem_en, s_mem_we, s_sel, s_busy;
  logic [1:0]       s_d_req, s_d_we;
  logic [1:0][31:0] s_if_addr, s_if_rdata, s_d_rdata, s_mem_addr, s_mem_wdata, s_mem_rdata;
  logic [1:0][31:0] s_d_addr, s_d_wdata;

  int          checks = 0;
  int          errors = 0;
  int          starve = 0;
  string       grants;
  logic [31:0] exp_if_rdata, exp_d_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .sel(sel), .busy(busy)
  );

  for (genvar g = 0; g < 2; g++) begin : g_sweep
    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(g == 0 ? 1 : 5), .STARVE_MAX(STARVE_MAX)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(s_if_req[g]), .if_addr(s_if_addr[g]), .if_ack(s_if_ack[g]), .if_rdata(s_if_rdata[g]),
      .d_req(s_d_req[g]), .d_we(s_d_we[g]), .d_addr(s_d_addr[g]), .d_wdata(s_d_wdata[g]),
      .d_ack(s_d_ack[g]), .d_rdata(s_d_rdata[g]),
      .mem_en(s_mem_en[g]), .mem_we(s_mem_we[g]), .mem_addr(s_mem_addr[g]),
      .mem_wdata(s_mem_wdata[g]), .mem_rdata(s_mem_rdata[g]), .sel(s_sel[g]), .busy(s_busy[g])
    );
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in an IDLE cycle (cycle 0); returns in the IDLE cycle MEM_LAT+3 with requests untouched
  // unless drop_at names the cycle in which both are deasserted.
  task automatic txn(input bit want_if, input bit want_d, input bit we,
                     input logic [31:0] ia, input logic [31:0] da, input logic [31:0] wd,
                     input logic [31:0] rd, input int drop_at, input string tag);
    bit          own_d;
    logic [31:0] exp_addr;
    if_req    = want_if;
    d_req     = want_d;
    d_we      = we;
    if_addr   = ia;
    d_addr    = da;
    d_wdata   = wd;
    mem_rdata = $urandom;
    own_d = want_d && (!want_if || starve < STARVE_MAX);
    if (own_d) begin
      if (want_if) starve++;
      grants = {grants, "D"};
    end else begin
      starve = 0;
      grants = {grants, "F"};
    end
    exp_addr = own_d ? da : ia;
    for (int k = 1; k <= LAT + 3; k++) begin
      tick();
      mem_rdata = (k == LAT + 1) ? rd : $urandom;
      if (k == drop_at) begin
        if_req = 1'b0;
        d_req  = 1'b0;
      end
      check({tag, "_mem_en"}, mem_en, k == 1);
      if (k == 1) begin
        check({tag, "_sel"}, sel, own_d);
        check({tag, "_mem_we"}, mem_we, own_d & we);
        check({tag, "_mem_addr"}, mem_addr, exp_addr);
        check({tag, "_mem_wdata"}, mem_wdata, wd);
      end
      if (k == LAT + 2) begin
        if (own_d) begin
          if (!we) exp_d_rdata = rd;
        end else begin
          exp_if_rdata = rd;
        end
        check({tag, "_acks"}, {if_ack, d_ack}, {!own_d, own_d});
        check({tag, "_if_rdata"}, if_rdata, exp_if_rdata);
        check({tag, "_d_rdata"}, d_rdata, exp_d_rdata);
      end else begin
        check({tag, "_no_ack"}, {if_ack, d_ack}, 2'b00);
      end
      check({tag, "_busy"}, busy, k <= LAT + 2);
    end
  endtask

  task automatic sweep(input int i, input int lat);
    logic [31:0] hist [0:15];
    int          ack_at = 0;
    s_if_req[i]    = 1'b1;
    s_if_addr[i]   = $urandom;
    s_mem_rdata[i] = $urandom;
    for (int k = 1; k <= lat + 6; k++) begin
      tick();
      s_mem_rdata[i] = $urandom;
      hist[k]        = s_mem_rdata[i];
      if (k == 1) check($sformatf("sweep%0d_mem_en", lat), s_mem_en[i], 1'b1);
      if (s_if_ack[i] && ack_at == 0) begin
        ack_at      = k;
        s_if_req[i] = 1'b0;
        check($sformatf("sweep%0d_rdata", lat), s_if_rdata[i], hist[lat + 1]);
      end
    end
    check($sformatf("sweep%0d_ack_cycle", lat), 64'(ack_at), 64'(lat + 2));
    check($sformatf("sweep%0d_idle", lat), s_busy[i], 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    {if_req, d_req, d_we} = '0;
    {if_addr, d_addr, d_wdata, mem_rdata} = '0;
    s_if_req = '0; s_d_req = '0; s_d_we = '0;
    s_if_addr = '0; s_d_addr = '0; s_d_wdata = '0; s_mem_rdata = '0;
    exp_if_rdata = '0;
    exp_d_rdata  = '0;
    grants       = "";

    repeat (2) tick();
    check("rst_busy", busy, 1'b0);
    check("rst_sel", sel, 1'b0);
    check("rst_mem_en", mem_en, 1'b0);
    check("rst_rdata", {if_rdata, d_rdata}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Directed: single fetch, store, load.
    txn(1, 0, 0, 32'h0040_0000, 32'h0, 32'h0, 32'h8C08_0004, 0, "fetch");
    txn(0, 1, 1, 32'h0, 32'h1001_0000, 32'hDEAD_BEEF, 32'h1234_5678, 0, "store");
    txn(0, 1, 0, 32'h0, 32'h1001_0004, 32'h0, 32'hCAFE_F00D, 0, "load");

    // Contention: both requests held across ten transactions.
    grants = "";
    for (int n = 0; n < 10; n++) txn(1, 1, 0, $urandom, $urandom, $urandom, $urandom, 0, "contend");
    checks++;
    assert (grants == "DDDDFDDDDF")
    else begin
      errors++;
      $error("FAIL grant_order: observed %s expected DDDDFDDDDF", grants);
    end

    // Randomized mix of requesters and loads/stores.
    for (int n = 0; n < 12; n++) begin
      bit wi, wd;
      wi = 1'($urandom);
      wd = 1'($urandom);
      if (!wi && !wd) wi = 1'b1;
      txn(wi, wd, 1'($urandom), $urandom, $urandom, $urandom, $urandom, 0, "rand");
    end

    // Early drop: load request withdrawn during WAIT still completes.
    txn(0, 1, 0, 32'h0, $urandom, 32'h0, $urandom, 2, "drop");
    tick();
    check("drop_idle_busy", busy, 1'b0);
    check("drop_idle_mem_en", mem_en, 1'b0);

    // Reset mid-WAIT of a data access.
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_addr = $urandom;
    tick();
    check("pre_rst_sel", sel, 1'b1);
    tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_mem_en", mem_en, 1'b0);
    check("mid_rst_sel", sel, 1'b0);
    check("mid_rst_acks", {if_ack, d_ack}, 2'b00);
    check("mid_rst_rdata", {if_rdata, d_rdata}, 64'h0);
    d_req        = 1'b0;
    starve       = 0;
    exp_if_rdata = '0;
    exp_d_rdata  = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("post_rst_busy", busy, 1'b0);
      check("post_rst_acks", {if_ack, d_ack}, 2'b00);
    end
    txn(1, 1, 0, $urandom, $urandom, $urandom, $urandom, 0, "post_rst");
    if_req = 1'b0;
    d_req  = 1'b0;

    // Latency sweep on the MEM_LAT=1 and MEM_LAT=5 instances.
    sweep(0, 1);
    sweep(1, 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
